hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Parametrised successor of the pipeline hazard detector for the RV32I core; sits beside the ID stage and drives the PC, IF/ID and ID/EX control.
- Adds a multi-bubble load-use stall for deeper data-memory latency, per-operand use qualification, branch flush, data-memory busy freeze, and saturating stall/flush counters.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_USE_STALLS, 1, bubbles needed for a load followed by a dependent instruction; legal values are 1 or 2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- idex_mem_read  input  1  the instruction in EX is a load.
- idex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
- exmem_mem_read  input  1  the instruction in MEM is a load; used only when LOAD_USE_STALLS=2.
- exmem_rd  input  REG_ADDR_W  destination register of the instruction in MEM.
- ifid_rs1  input  REG_ADDR_W  rs1 of the instruction in ID.
- ifid_rs2  input  REG_ADDR_W  rs2 of the instruction in ID.
- ifid_uses_rs1  input  1  the ID instruction reads rs1.
- ifid_uses_rs2  input  1  the ID instruction reads rs2.
- branch_taken  input  1  a branch or jump in EX resolved as taken.
- mem_busy  input  1  data memory is not ready; the whole pipeline must freeze.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register write enable.
- idex_bubble  output  1  insert a NOP into ID/EX.
- ifid_flush  output  1  clear IF/ID.
- back_hold  output  1  hold the EX/MEM and MEM/WB registers.
- stall_cycles  output  CNT_W  number of cycles with pc_write=0; saturates at the maximum value.
- flush_count  output  CNT_W  number of flush events; saturates at the maximum value.

Behaviour:
- State machine has two states:
  - RUN.
  - LU_STALL, with a remaining-bubble counter rem of width 1.
- Reset: on a clk edge with rst_n=0, state goes to RUN and rem, stall_cycles and flush_count go to 0.
- While rst_n=0, outputs are forced to pc_write=1, ifid_write=1 and all others 0.
- Control outputs are combinational from state and inputs, so they act in the same cycle. There is zero-cycle detection latency.
- Default outputs: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, back_hold=0.
- Load-use hit A: idex_mem_read, idex_rd!=0, and either (ifid_uses_rs1 and idex_rd==ifid_rs1) or (ifid_uses_rs2 and idex_rd==ifid_rs2).
- Load-use hit B (LOAD_USE_STALLS=2 only): the same test using exmem_mem_read and exmem_rd.
- Priority in every state, highest first:
  1. mem_busy: back_hold=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0. State and rem are held. branch_taken is ignored; it persists because EX is held.
  2. branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. flush_count increments. Next state is RUN and rem=0, which aborts any load-use stall.
  3. LU_STALL: pc_write=0, ifid_write=0, idex_bubble=1. If rem=0 next state is RUN, otherwise rem decrements.
  4. RUN with hit A: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_USE_STALLS=2, go to LU_STALL with rem=0, giving 2 bubbles in total. Otherwise stay in RUN.
  5. RUN with hit B and no hit A: one bubble, as in case 4, staying in RUN.
- stall_cycles increments on every post-reset cycle with pc_write=0, including mem_busy cycles.
- Both counters saturate at 2^CNT_W−1 and do not wrap.
- Register x0 never causes a stall.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W.
  - the state typedef {RUN, LU_STALL}.
  - the NOP-insertion constant.
- Sub-module sat_counter (parameter CNT_W; ports clk, rst_n, inc, count) is instantiated twice.

Test Plan:
- LOAD_USE_STALLS=1; idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 -> in that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle defaults; stall_cycles=1.
- Same as above but ifid_uses_rs2=0, or idex_rd=0 -> no stall; stall_cycles stays 0.
- LOAD_USE_STALLS=2; hit A with rd=7, rs1=7 -> 2 consecutive bubble cycles, then RUN. Separately, hit B alone (exmem_rd=7) -> exactly 1 bubble.
- LOAD_USE_STALLS=2; mem_busy=1 for 3 cycles during the LU_STALL cycle -> back_hold=1 for 3 cycles with the stall held, then 1 bubble cycle; stall_cycles=5.
- branch_taken=1 together with hit A -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_count=1, next state RUN. With mem_busy=1 also asserted, the flush is deferred until mem_busy falls.
- rst_n=0 asserted in LU_STALL -> next edge gives RUN with counters 0; outputs stay at defaults while rst_n=0. Also force stall_cycles to 2^16−1 and stall once more -> it stays at 65535.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the RV32I hazard control unit.
package hazard_control_unit_pkg;

  // Register index width of the RV32I register file.
  localparam int unsigned REG_ADDR_W = 5;

  // Instruction word injected into ID/EX when a bubble is inserted (addi x0, x0, 0).
  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Hazard controller states.
  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next value: increment unless already pinned at the maximum.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flush, memory-busy freeze
// and saturating performance counters. Control outputs are combinational so
// they act in the cycle the hazard is seen.
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_W      = hazard_control_unit_pkg::REG_ADDR_W,
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  exmem_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs1,
  input  logic                  ifid_uses_rs2,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  back_hold,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  import hazard_control_unit_pkg::*;

  localparam bit TWO_STALLS = (LOAD_USE_STALLS == 2);

  hcu_state_e state_q, state_d;
  logic       rem_q, rem_d;
  logic       hit_a, hit_b;
  logic       flush_inc, stall_inc;

  // Load-use dependency against the load in EX (x0 never matches).
  always_comb begin
    hit_a = idex_mem_read && (idex_rd != '0) &&
            ((ifid_uses_rs1 && (idex_rd == ifid_rs1)) ||
             (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  end

  // Load-use dependency against the load in MEM; only relevant for 2-cycle loads.
  always_comb begin
    hit_b = TWO_STALLS && exmem_mem_read && (exmem_rd != '0) &&
            ((ifid_uses_rs1 && (exmem_rd == ifid_rs1)) ||
             (ifid_uses_rs2 && (exmem_rd == ifid_rs2)));
  end

  // Next-state and control outputs, highest-priority condition first.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    back_hold   = 1'b0;
    flush_inc   = 1'b0;

    if (!rst_n) begin
      state_d = RUN;
      rem_d   = 1'b0;
    end else if (mem_busy) begin
      // Freeze everything; a pending branch stays in EX and is seen later.
      back_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      state_d     = RUN;
      rem_d       = 1'b0;
    end else if (state_q == LU_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (rem_q == 1'b0) begin
        state_d = RUN;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end else if (hit_a) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (TWO_STALLS) begin
        state_d = LU_STALL;
        rem_d   = 1'b0;
      end
    end else if (hit_b) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign stall_inc = rst_n && !pc_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: 1-stall, 2-stall and narrow-counter instances.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic       idex_mem_read, exmem_mem_read;
  logic [4:0] idex_rd, exmem_rd, ifid_rs1, ifid_rs2;
  logic       ifid_uses_rs1, ifid_uses_rs2, branch_taken, mem_busy;

  logic        pcw1, ifw1, bub1, fl1, hold1;
  logic [15:0] stall1, flushc1;
  logic        pcw2, ifw2, bub2, fl2, hold2;
  logic [15:0] stall2, flushc2;
  logic        pcw3, ifw3, bub3, fl3, hold3;
  logic [3:0]  stall3, flushc3;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd), .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2), .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pcw1),
    .ifid_write(ifw1), .idex_bubble(bub1), .ifid_flush(fl1), .back_hold(hold1),
    .stall_cycles(stall1), .flush_count(flushc1));

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd), .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2), .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pcw2),
    .ifid_write(ifw2), .idex_bubble(bub2), .ifid_flush(fl2), .back_hold(hold2),
    .stall_cycles(stall2), .flush_count(flushc2));

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd), .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2), .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pcw3),
    .ifid_write(ifw3), .idex_bubble(bub3), .ifid_flush(fl3), .back_hold(hold3),
    .stall_cycles(stall3), .flush_count(flushc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic       xmr;
    logic [4:0] xrd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic       busy;
    logic [4:0] exp;  // {pc_write, ifid_write, idex_bubble, ifid_flush, back_hold}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    idex_mem_read  = 1'b0;
    idex_rd        = 5'd0;
    exmem_mem_read = 1'b0;
    exmem_rd       = 5'd0;
    ifid_rs1       = 5'd0;
    ifid_rs2       = 5'd0;
    ifid_uses_rs1  = 1'b0;
    ifid_uses_rs2  = 1'b0;
    branch_taken   = 1'b0;
    mem_busy       = 1'b0;
  endtask

  task automatic hit_a7();
    idle();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd7;
    ifid_rs1      = 5'd7;
    ifid_uses_rs1 = 1'b1;
  endtask

  // Reset over one rising edge; returns at a falling edge with rst_n released.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int ctl2();
    return int'({pcw2, ifw2, bub2, fl2, hold2});
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();

    vecs[0] = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100};
    vecs[1] = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    vecs[2] = '{1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11000};
    vecs[3] = '{1'b0, 5'd5, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000};
    vecs[4] = '{1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00100};
    vecs[5] = '{1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000};
    vecs[6] = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11110};
    vecs[7] = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001};
    vecs[8] = '{1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00001};
    vecs[9] = '{1'b0, 5'd0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000};

    // Outputs forced to defaults while in reset, even with a hazard present.
    @(negedge clk);
    hit_a7();
    #1;
    chk("reset_outputs", ctl2(), 5'b11000);
    @(posedge clk);
    @(negedge clk);
    chk("reset_stall_cnt", int'(stall2), 0);
    chk("reset_flush_cnt", int'(flushc2), 0);
    do_reset();

    // Single-cycle table on the 1-bubble instance.
    for (int i = 0; i < 10; i++) begin
      idex_mem_read  = vecs[i].mr;
      idex_rd        = vecs[i].rd;
      exmem_mem_read = vecs[i].xmr;
      exmem_rd       = vecs[i].xrd;
      ifid_rs1       = vecs[i].rs1;
      ifid_rs2       = vecs[i].rs2;
      ifid_uses_rs1  = vecs[i].use1;
      ifid_uses_rs2  = vecs[i].use2;
      branch_taken   = vecs[i].br;
      mem_busy       = vecs[i].busy;
      #1;
      chk($sformatf("vec%0d_ctl", i), int'({pcw1, ifw1, bub1, fl1, hold1}), int'(vecs[i].exp));
      @(negedge clk);
    end
    idle();
    #1;
    chk("tbl_after_default", int'({pcw1, ifw1, bub1, fl1, hold1}), 5'b11000);
    chk("tbl_stall_cnt", int'(stall1), 4);
    chk("tbl_flush_cnt", int'(flushc1), 1);

    // Two-bubble load-use: hit A, then a bubble from LU_STALL alone, then RUN.
    do_reset();
    hit_a7();
    #1;
    chk("lu2_c1", ctl2(), 5'b00100);
    @(negedge clk);
    idle();
    #1;
    chk("lu2_c2", ctl2(), 5'b00100);
    @(negedge clk);
    #1;
    chk("lu2_c3", ctl2(), 5'b11000);
    chk("lu2_stall_cnt", int'(stall2), 2);

    // Hit B alone gives exactly one bubble.
    do_reset();
    exmem_mem_read = 1'b1;
    exmem_rd       = 5'd7;
    ifid_rs1       = 5'd7;
    ifid_uses_rs1  = 1'b1;
    #1;
    chk("hitb_c1", ctl2(), 5'b00100);
    chk("hitb_u1_ignored", int'(bub1), 0);
    @(negedge clk);
    idle();
    #1;
    chk("hitb_c2", ctl2(), 5'b11000);
    chk("hitb_stall_cnt", int'(stall2), 1);

    // mem_busy for 3 cycles during LU_STALL: held, then the remaining bubble.
    do_reset();
    hit_a7();
    #1;
    chk("busy_c1", ctl2(), 5'b00100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      mem_busy = 1'b1;
      #1;
      chk($sformatf("busy_hold%0d", i), ctl2(), 5'b00001);
    end
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    chk("busy_resume", ctl2(), 5'b00100);
    @(negedge clk);
    #1;
    chk("busy_run", ctl2(), 5'b11000);
    chk("busy_stall_cnt", int'(stall2), 5);

    // Branch beats a load-use hit and does not enter LU_STALL.
    do_reset();
    hit_a7();
    branch_taken = 1'b1;
    #1;
    chk("br_ctl", ctl2(), 5'b11110);
    @(negedge clk);
    idle();
    #1;
    chk("br_next_run", ctl2(), 5'b11000);
    chk("br_flush_cnt", int'(flushc2), 1);
    chk("br_stall_cnt", int'(stall2), 0);
    // Branch under mem_busy is deferred until busy drops.
    branch_taken = 1'b1;
    mem_busy     = 1'b1;
    #1;
    chk("br_busy_ctl", ctl2(), 5'b00001);
    @(negedge clk);
    chk("br_busy_flush_cnt", int'(flushc2), 1);
    mem_busy = 1'b0;
    #1;
    chk("br_after_busy_ctl", ctl2(), 5'b11110);
    @(negedge clk);
    idle();
    chk("br_after_busy_cnt", int'(flushc2), 2);

    // Reset asserted while in LU_STALL.
    do_reset();
    hit_a7();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_in_lu_ctl", ctl2(), 5'b11000);
    @(negedge clk);
    idle();
    #1;
    chk("rst_in_lu_stall_cnt", int'(stall2), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_lu_run", ctl2(), 5'b11000);

    // Saturation: 20 stall cycles on a 4-bit counter pins at 15.
    do_reset();
    idle();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd5;
    ifid_rs2      = 5'd5;
    ifid_uses_rs2 = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    idle();
    chk("sat_narrow", int'(stall3), 15);
    chk("sat_wide", int'(stall1), 20);
    @(negedge clk);
    chk("sat_hold", int'(stall3), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
